// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared depth/pointer helpers and level legality checks for sync_fifo_block
package fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic int fifo_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

   // One extra bit lets full and empty be told apart when the addresses match.
   function automatic int ptr_width(input int addr_size);
      return addr_size + 1;
   endfunction

   function automatic bit levels_legal(input int addr_size, input int af_level, input int ae_level);
      return (af_level >= 1) && (af_level <= fifo_depth(addr_size)) &&
             (ae_level >= 0) && (ae_level <= fifo_depth(addr_size) - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_block_if.sv
// rtl/sync_fifo_block_if.sv - push/pop/status bundle between the register side and the FIFO
interface sync_fifo_block_if #(
   parameter int data_size = 8,
   parameter int addr_size = 4
);
   logic                   clear_i;
   logic                   write_inc_i;
   logic [data_size-1:0]   data_i;
   logic                   read_inc_i;
   logic [data_size-1:0]   data_o;
   logic                   data_valid_o;
   logic                   read_empty_o;
   logic                   read_almost_empty_o;
   logic                   write_full_o;
   logic                   write_almost_full_o;
   logic [addr_size:0]     fill_level_o;
   logic                   overflow_o;
   logic                   underflow_o;

   modport master (
      output clear_i, write_inc_i, data_i, read_inc_i,
      input  data_o, data_valid_o, read_empty_o, read_almost_empty_o,
             write_full_o, write_almost_full_o, fill_level_o, overflow_o, underflow_o
   );

   modport slave (
      input  clear_i, write_inc_i, data_i, read_inc_i,
      output data_o, data_valid_o, read_empty_o, read_almost_empty_o,
             write_full_o, write_almost_full_o, fill_level_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - single-clock register array, one write port, asynchronous read address
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int data_size = 8,
   parameter int addr_size = 4
) (
   input  logic                 clock_i,
   input  logic                 we_i,
   input  logic [addr_size-1:0] waddr_i,
   input  logic [data_size-1:0] wdata_i,
   input  logic [addr_size-1:0] raddr_i,
   output logic [data_size-1:0] rdata_o
);
   localparam int DEPTH = fifo_depth(addr_size);

   logic [data_size-1:0] mem_q [DEPTH];

   // Storage carries no reset; occupancy is tracked entirely by the pointers.
   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_block.sv
// rtl/sync_fifo_block.sv - single-clock byte FIFO with level flags, sticky errors and flush
// SYNC_FIFO_FWFT_EN selects first-word fall-through output instead of the registered read.
module sync_fifo_block
   import fifo_pkg::*;
#(
   parameter int data_size          = 8,
   parameter int addr_size          = 4,
   parameter int almost_full_level  = 14,
   parameter int almost_empty_level = 2
) (
   input  logic          clock_i,
   input  logic          reset_n_i,
   sync_fifo_block_if.slave bus
);
   localparam int PTR_W = ptr_width(addr_size);
   localparam int DEPTH = fifo_depth(addr_size);
   localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_L    = PTR_W'(almost_full_level);
   localparam logic [PTR_W-1:0] AE_L    = PTR_W'(almost_empty_level);
   localparam bit LEVELS_OK = levels_legal(addr_size, almost_full_level, almost_empty_level);

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     level_q, level_d;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;
   logic                 full, empty, wr_acc, rd_acc;
   fifo_op_e             op;
   logic [data_size-1:0] rdata;

   always_comb begin
      full     = (level_q == DEPTH_L);
      empty    = (level_q == '0);
      // Flush wins over any request in the same cycle.
      wr_acc   = bus.write_inc_i && !full  && !bus.clear_i;
      rd_acc   = bus.read_inc_i  && !empty && !bus.clear_i;
      op       = fifo_op_e'({rd_acc, wr_acc});
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q || (bus.write_inc_i && full);
      udf_d    = udf_q || (bus.read_inc_i && empty);
      if (bus.clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         case (op)
            OP_WRITE: begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               level_d  = level_q + 1'b1;
            end
            OP_READ: begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               level_d  = level_q - 1'b1;
            end
            OP_BOTH: begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clock_i) begin
      assert (LEVELS_OK) else $error("sync_fifo_block: almost_full/almost_empty level out of range");
   end

   sync_fifo_mem #(
      .data_size (data_size),
      .addr_size (addr_size)
   ) u_mem (
      .clock_i (clock_i),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[addr_size-1:0]),
      .wdata_i (bus.data_i),
      .raddr_i (rd_ptr_q[addr_size-1:0]),
      .rdata_o (rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.data_o       = rdata;
   assign bus.data_valid_o = !empty;
`else
   logic [data_size-1:0] dout_q, dout_d;
   logic                 dvalid_q, dvalid_d;

   always_comb begin
      dout_d   = rd_acc ? rdata : dout_q;
      dvalid_d = rd_acc;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         dout_q   <= '0;
         dvalid_q <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign bus.data_o       = dout_q;
   assign bus.data_valid_o = dvalid_q;
`endif

   assign bus.read_empty_o        = empty;
   assign bus.read_almost_empty_o = (level_q <= AE_L);
   assign bus.write_full_o        = full;
   assign bus.write_almost_full_o = (level_q >= AF_L);
   assign bus.fill_level_o        = level_q;
   assign bus.overflow_o          = ovf_q;
   assign bus.underflow_o         = udf_q;
endmodule

// File: tb/tb_sync_fifo_block.sv
// tb/tb_sync_fifo_block.sv - self-checking bench for sync_fifo_block (either read mode)
module tb_sync_fifo_block;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sync_fifo_block_if #(.data_size(8), .addr_size(4)) bus ();

   sync_fifo_block #(
      .data_size          (8),
      .addr_size          (4),
      .almost_full_level  (14),
      .almost_empty_level (2)
   ) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   // Reference model: a queue of stored words plus the sticky/registered outputs.
   logic [7:0] mq[$];
   bit         m_ovf, m_udf, m_dv;
   logic [7:0] m_dout;

   typedef struct {
      bit         wr, rd, clr;
      logic [7:0] din;
      int         lvl;
      bit         ovf, udf, dv;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dv   = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic model_edge(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
      bit was_full, was_empty;
      if (clr) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_dv  = 1'b0;
         return;
      end
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      m_dv = 1'b0;
      if (rd && !was_empty) begin
         m_dout = mq.pop_front();
         m_dv   = 1'b1;
      end
      if (wr && !was_full) mq.push_back(d);
   endtask

   task automatic step(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
      bus.write_inc_i = wr;
      bus.read_inc_i  = rd;
      bus.clear_i     = clr;
      bus.data_i      = d;
      model_edge(wr, rd, clr, d);
      @(posedge clk);
      @(negedge clk);
      bus.write_inc_i = 1'b0;
      bus.read_inc_i  = 1'b0;
      bus.clear_i     = 1'b0;
   endtask

   task automatic check_model(input string tag);
      int n;
      n = mq.size();
      check({tag, ".level"},     32'(bus.fill_level_o),        32'(n));
      check({tag, ".empty"},     32'(bus.read_empty_o),        32'(n == 0));
      check({tag, ".aempty"},    32'(bus.read_almost_empty_o), 32'(n <= 2));
      check({tag, ".full"},      32'(bus.write_full_o),        32'(n == 16));
      check({tag, ".afull"},     32'(bus.write_almost_full_o), 32'(n >= 14));
      check({tag, ".overflow"},  32'(bus.overflow_o),          32'(m_ovf));
      check({tag, ".underflow"}, 32'(bus.underflow_o),         32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
      check({tag, ".valid"},     32'(bus.data_valid_o),        32'(n != 0));
      if (n != 0) check({tag, ".head"}, 32'(bus.data_o), 32'(mq[0]));
`else
      check({tag, ".valid"},     32'(bus.data_valid_o),        32'(m_dv));
      check({tag, ".data"},      32'(bus.data_o),              32'(m_dout));
`endif
   endtask

   task automatic fill(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, base + 8'(i));
   endtask

   initial begin
      logic [7:0] v;
      bus.clear_i     = 1'b0;
      bus.write_inc_i = 1'b0;
      bus.read_inc_i  = 1'b0;
      bus.data_i      = 8'h00;
      model_reset();

      //            wr rd clr din    lvl ovf udf dv dout
      tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h33, 2, 1'b0, 1'b1, 1'b1, 8'h11};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1, 8'h22};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h44, 0, 1'b0, 1'b0, 1'b0, 8'h22};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h22};

      repeat (2) @(negedge clk);
      check("reset.level",  32'(bus.fill_level_o),        32'd0);
      check("reset.empty",  32'(bus.read_empty_o),        32'd1);
      check("reset.aempty", 32'(bus.read_almost_empty_o), 32'd1);
      check("reset.full",   32'(bus.write_full_o),        32'd0);
      check("reset.afull",  32'(bus.write_almost_full_o), 32'd0);
      check("reset.ovf",    32'(bus.overflow_o),          32'd0);
      check("reset.udf",    32'(bus.underflow_o),         32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("reset.valid",  32'(bus.data_valid_o),        32'd0);
      check("reset.data",   32'(bus.data_o),              32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
         check($sformatf("tbl%0d.level", i), 32'(bus.fill_level_o), 32'(tbl[i].lvl));
         check($sformatf("tbl%0d.ovf", i),   32'(bus.overflow_o),   32'(tbl[i].ovf));
         check($sformatf("tbl%0d.udf", i),   32'(bus.underflow_o),  32'(tbl[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
         check($sformatf("tbl%0d.valid", i), 32'(bus.data_valid_o), 32'(tbl[i].dv));
         check($sformatf("tbl%0d.data", i),  32'(bus.data_o),       32'(tbl[i].dout));
`endif
      end

      // Fill and drain across the almost-full and full thresholds.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i));
         check("fill.level", 32'(bus.fill_level_o),        32'(i + 1));
         check("fill.afull", 32'(bus.write_almost_full_o), 32'((i + 1) >= 14));
         check("fill.full",  32'(bus.write_full_o),        32'((i + 1) == 16));
      end
      for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("drain.head", 32'(bus.data_o), 32'(i));
         step(1'b0, 1'b1, 1'b0, 8'h00);
`else
         step(1'b0, 1'b1, 1'b0, 8'h00);
         check("drain.data",  32'(bus.data_o),       32'(i));
         check("drain.valid", 32'(bus.data_valid_o), 32'd1);
`endif
      end
      check("drain.empty", 32'(bus.read_empty_o), 32'd1);
      check("drain.level", 32'(bus.fill_level_o), 32'd0);

      // Overflow is sticky until flushed.
      fill(16, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'hAA);
      check("ovf.level", 32'(bus.fill_level_o), 32'd16);
      check("ovf.flag",  32'(bus.overflow_o),   32'd1);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("ovf.sticky", 32'(bus.overflow_o), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      check("ovf.head", 32'(bus.data_o), 32'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
`else
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("ovf.read", 32'(bus.data_o), 32'h00);
`endif
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("ovf.clear", 32'(bus.overflow_o),   32'd0);
      check("ovf.level0", 32'(bus.fill_level_o), 32'd0);

      // Underflow on an empty read.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("udf.flag",  32'(bus.underflow_o),  32'd1);
      check("udf.valid", 32'(bus.data_valid_o), 32'd0);
      check("udf.level", 32'(bus.fill_level_o), 32'd0);

      // Steady level 8 with simultaneous access, wrapping the pointers.
      step(1'b0, 1'b0, 1'b1, 8'h00);
      v = 8'h40;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, v);
         v++;
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0, v);
         v++;
         check("simul.level", 32'(bus.fill_level_o), 32'd8);
         check_model("simul");
      end

      // Full with both requests: read wins, write is dropped.
      step(1'b0, 1'b0, 1'b1, 8'h00);
      fill(16, 8'h80);
      step(1'b1, 1'b1, 1'b0, 8'hEE);
      check("fullboth.level", 32'(bus.fill_level_o), 32'd15);
      check("fullboth.ovf",   32'(bus.overflow_o),   32'd1);
      check_model("fullboth");

      // Asynchronous reset between edges with a write pending.
      step(1'b0, 1'b0, 1'b1, 8'h00);
      fill(5, 8'h60);
      bus.write_inc_i = 1'b1;
      bus.data_i      = 8'h99;
      #2;
      rst_n = 1'b0;
      #1;
      check("areset.level", 32'(bus.fill_level_o), 32'd0);
      check("areset.empty", 32'(bus.read_empty_o), 32'd1);
      check("areset.valid", 32'(bus.data_valid_o), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("areset.data",  32'(bus.data_o),       32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      check("areset.hold", 32'(bus.fill_level_o), 32'd0);
      bus.write_inc_i = 1'b0;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);

      // Flush beats a concurrent write.
      fill(3, 8'h10);
      step(1'b1, 1'b0, 1'b1, 8'h77);
      check("clrwr.level", 32'(bus.fill_level_o), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      check("fwft.data",  32'(bus.data_o),       32'h5A);
      check("fwft.valid", 32'(bus.data_valid_o), 32'd1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("fwft.empty", 32'(bus.read_empty_o), 32'd1);
`endif

      // Random traffic, biased in phases to visit both full and empty.
      for (int c = 0; c < 400; c++) begin
         bit wr, rd, clr;
         if (((c / 50) % 2) == 0) begin
            wr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0);
         end else begin
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
         end
         clr = ($urandom_range(0, 63) == 0);
         step(wr, rd, clr, 8'($urandom));
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo_block.md
Name: sync_fifo_block

Overview:
- Single-clock successor to the dual-clock FIFO top, for I2C byte buffering where master/slave core and register interface share one clock.
- Generalised depth/width with parameterised almost-full/almost-empty levels, an exposed fill level, sticky overflow/underflow error flags and a synchronous flush.
- Sits between the register interface and the I2C shift engine, one instance per direction (TX, RX).

Parameters:
- data_size, 8, width of each stored word in bits.
- addr_size, 4, address width; depth = 2**addr_size (16 by default).
- almost_full_level, 14, write_almost_full_o asserts when fill level >= this value; legal range 1..depth.
- almost_empty_level, 2, read_almost_empty_o asserts when fill level <= this value; legal range 0..depth-1.

Ports:
- clock_i  in  1  the single block clock; all logic is on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- write_inc_i  in  1  write request; pushes data_i when not full.
- data_i  in  data_size  write data.
- read_inc_i  in  1  read request; pops one word when not empty.
- data_o  out  data_size  read data.
- data_valid_o  out  1  data_o holds a newly popped word.
- read_empty_o  out  1  fill level == 0.
- read_almost_empty_o  out  1  fill level <= almost_empty_level.
- write_full_o  out  1  fill level == depth.
- write_almost_full_o  out  1  fill level >= almost_full_level.
- fill_level_o  out  addr_size+1  current occupancy, 0..depth.
- overflow_o  out  1  sticky flag: a write was attempted while full.
- underflow_o  out  1  sticky flag: a read was attempted while empty.

Behaviour:
- Pointers: write and read pointers are addr_size+1-bit binary and wrap modulo 2*depth. The storage address is the low addr_size bits. Fill level is a registered counter.
- Accept rules use pre-edge flags:
  - write accepted = write_inc_i && !write_full_o.
  - read accepted = read_inc_i && !read_empty_o.
- Fill update:
  - Write only accepted: +1.
  - Read only accepted: -1.
  - Both accepted: unchanged, both pointers advance.
- Boundary cases:
  - Full with both requests: only the read is accepted; the write is dropped and overflow_o sets.
  - Empty with both requests: only the write is accepted; underflow_o sets.
- Flags: all status flags are combinational decodes of the registered fill level, so they reflect the state after each edge.
- Storage: the register array is written on the edge of an accepted write. Memory is not reset and not cleared.
- Read path, standard mode:
  - On an accepted read, data_o <= mem[read addr] and data_valid_o = 1 for exactly one cycle. Read latency is 1 cycle.
  - data_o holds its value otherwise.
- clear_i:
  - Has priority over write_inc_i and read_inc_i in the same cycle.
  - Sets both pointers and fill level to 0, clears overflow_o and underflow_o, and forces data_valid_o to 0.
  - data_o keeps its value.
- Sticky flags: overflow_o and underflow_o set on the edge of the offending request and hold until clear_i or reset.
- Reset values:
  - Pointers 0, fill_level_o 0, data_o 0, data_valid_o 0.
  - read_empty_o 1, read_almost_empty_o 1, write_full_o 0.
  - write_almost_full_o 0 (given almost_full_level >= 1).
  - overflow_o 0, underflow_o 0.
- Reset mid-operation: asynchronous, takes effect immediately; any in-flight write or read is discarded.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_o = mem[read addr] combinationally, i.e. the head word is presented without a read.
  - data_valid_o = !read_empty_o.
  - read_inc_i acknowledges and pops the head.
  - A word written into an empty FIFO is visible on data_o the cycle after the write edge.
- Undefined: standard 1-cycle registered read as described in Behaviour.
- Flags, fill level and error behaviour are identical in both modes.

Decomposition:
- Shared package/include fifo_pkg:
  - Depth calculation from addr_size.
  - Pointer width constant (addr_size+1).
  - Parameter-legality checks on the almost-full/almost-empty levels.
- Sub-module sync_fifo_mem: a single-clock register array with a write port and an asynchronous read address.
- Pointers, counter, flags and the output register stay in the top.

Test Plan (data_size=8, addr_size=4, levels 14/2):
- Fill/drain: write 0x00..0x0F with no reads -> write_almost_full_o at level 14, write_full_o at 16; read 16 -> data 0x00..0x0F in order, read_empty_o=1, fill_level_o=0.
- Overflow: at full, write 0xAA -> write dropped, overflow_o=1 and sticky; a subsequent read returns 0x00; clear_i -> overflow_o=0, fill_level_o=0.
- Underflow: read while empty -> underflow_o=1, data_valid_o stays 0, fill_level_o stays 0.
- Simultaneous access:
  - Level 8, write and read together for 20 cycles -> fill_level_o stays 8, ordering preserved across pointer wrap.
  - At full, both requests -> level 15, overflow_o=1.
- Reset and clear:
  - Assert reset_n_i low asynchronously while level 5 with a write pending -> all outputs at reset values immediately, no pop occurs.
  - clear_i with write_inc_i asserted -> level 0.
- FWFT build: write 0x5A into empty -> data_o=0x5A and data_valid_o=1 on the next cycle with no read; read_inc_i -> read_empty_o=1.
